uart_tx: RTL

// - 8N1 UART transmitter. Drives the board TX pin so the controller can reply to host commands
//   (acks, parameter readback, status).
// - Mirror of the existing receive path: same bit timing and same one-cycle byte strobe, used in
//   the opposite direction.
// - A small FIFO decouples the command/response logic from line timing.
// - Sits in pewpew next to the receiver; its TX output drives the board TX pin.

---
 rtl/uart_pkg.sv | 18 +
 rtl/byte_fifo.sv | 64 ++++++
 rtl/uart_tx.sv | 125 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions: data width, FSM states, bit-period helper
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // Clock cycles per serial bit
    function automatic int calc_period(input int clock_freq_hz, input int baud_rate);
        return clock_freq_hz / baud_rate;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - synchronous FIFO with count-based full/empty
module byte_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] COUNT_FULL = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic [PW:0]      count_d;
    logic             wr_ok;
    logic             rd_ok;

    // full is the registered flag, so a write against a full FIFO is refused even when a pop
    // happens in the same cycle
    assign wr_ok   = wr_en & ~full;
    assign rd_ok   = rd_en & ~empty;
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // Next occupancy from the accepted write and pop
    always_comb begin
        count_d = count;
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count + (PW + 1)'(1);
            2'b01:   count_d = count - (PW + 1)'(1);
            default: count_d = count;
        endcase
    end

    // Pointers, occupancy and full flag
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + PW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + PW'(1);
            count <= count_d;
            full  <= (count_d == COUNT_FULL);
        end
    end

    // Storage array; contents are don't-care while empty, so it needs no reset
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter with a small byte FIFO ahead of the shifter
module uart_tx
    import uart_pkg::*;
#(
    parameter int PERIOD     = calc_period(12_000_000, 9600),
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] in_byte,
    input  logic       latch,
    output logic       full,
    output logic       overflow,
    output logic       busy,
    output logic       TX
);

    localparam int                CW       = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0]     CNT_LOAD = CW'(PERIOD - 1);
    localparam logic [2:0]        LAST_IDX = 3'(UART_DATA_BITS - 1);

    uart_state_t                  state_q, state_d;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic [2:0]                   idx_q, idx_d;
    logic [UART_DATA_BITS-1:0]    shift_q, shift_d;
    logic                         tx_d;
    logic                         busy_d;
    logic                         pop;
    logic                         fifo_empty;
    logic [UART_DATA_BITS-1:0]    fifo_head;

    byte_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (latch),
        .wr_data (in_byte),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .full    (full),
        .empty   (fifo_empty)
    );

    // Next state, counters, shifter and pop; TX and busy follow the current state one cycle later
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        pop     = 1'b0;
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_head;
                    cnt_d   = CNT_LOAD;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    cnt_d   = CNT_LOAD;
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    shift_d = shift_q >> 1;
                    cnt_d   = CNT_LOAD;
                    if (idx_q == LAST_IDX) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (cnt_q == '0) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_head;
                        cnt_d   = CNT_LOAD;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        case (state_q)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_q[0];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_q != IDLE) | ~fifo_empty;
    end

    // State and output registers; reset aborts any frame and parks the line high
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            TX       <= 1'b1;
            busy     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            TX       <= tx_d;
            busy     <= busy_d;
            overflow <= latch & full;
        end
    end

endmodule
